// File: rtl/uart_rx_oversampled_if.sv
// Receiver-side bundle: serial line and arm control in, received word, handshake and status out.
interface uart_rx_oversampled_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx;
  logic                 rx_en;
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 data_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;

  modport master (
    output rx, rx_en, data_ready,
    input  data_out, data_valid, parity_err, frame_err, overrun, busy
  );

  modport slave (
    input  rx, rx_en, data_ready,
    output data_out, data_valid, parity_err, frame_err, overrun, busy
  );
endinterface

// File: rtl/uart_rx_oversampled.sv
// Oversampling UART receiver: start-bit validation, mid-bit sampling, configurable
// frame format, and a valid/ready output stage with parity, framing and overrun flags.
module uart_rx_oversampled #(
  parameter int DATA_BITS     = 8,
  parameter int OVERSAMPLE    = 16,
  parameter int CLKS_PER_TICK = 27,
  parameter int PARITY_EN     = 0,
  parameter int PARITY_ODD    = 0,
  parameter int STOP_BITS     = 1
) (
  input logic                  clk,
  input logic                  rst,
  uart_rx_oversampled_if.slave bus
);

  localparam int TW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_TICK - 1);
  localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] BIT_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic          ODD       = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK_WAIT} state_t;

  state_t               state;
  logic                 rx_m, rx_s, rx_d;
  logic [TW-1:0]        tick_cnt;
  logic [SW-1:0]        samp_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_err, frm_err, done, busy_r;
  logic                 tick, mid, start_det;

  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, perr_q, ferr_q, ovr_q;

  // Synchroniser flops reset to the idle level so reset never fakes a start edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= bus.rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  assign start_det = (state == IDLE) && bus.rx_en && rx_d && !rx_s;
  assign tick      = (tick_cnt == TICK_LAST);
  assign mid       = tick && (samp_cnt == ((state == START) ? HALF_LAST : BIT_LAST));

  always_ff @(posedge clk) begin
    if (!rst || start_det) tick_cnt <= '0;
    else if (tick)         tick_cnt <= '0;
    else                   tick_cnt <= tick_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      busy_r   <= 1'b0;
      samp_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_err  <= 1'b0;
      frm_err  <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (tick) samp_cnt <= mid ? '0 : samp_cnt + 1'b1;
      case (state)
        IDLE: if (start_det) begin
          state    <= START;
          busy_r   <= 1'b1;
          samp_cnt <= '0;
          bit_cnt  <= '0;
          par_err  <= 1'b0;
          frm_err  <= 1'b0;
        end
        START: if (mid) begin
          if (rx_s) begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end else begin
            state <= DATA;
          end
        end
        DATA: if (mid) begin
          shreg <= {rx_s, shreg[DATA_BITS-1:1]};
          if (bit_cnt == DATA_LAST) begin
            bit_cnt <= '0;
            state   <= (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        PARITY: if (mid) begin
          par_err <= ((^shreg) ^ rx_s) != ODD;
          state   <= STOP;
        end
        STOP: if (mid) begin
          frm_err <= frm_err | ~rx_s;
          if (bit_cnt == STOP_LAST) begin
            bit_cnt <= '0;
            done    <= 1'b1;
            // Line still low after the last stop bit: wait for idle so a break never retriggers.
            if (rx_s) begin
              state  <= IDLE;
              busy_r <= 1'b0;
            end else begin
              state <= BREAK_WAIT;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        BREAK_WAIT: if (rx_s) begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  // Output stage: a completing frame loads only if the slot is empty or being drained this cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else if (done) begin
      if (!valid_q || bus.data_ready) begin
        data_q  <= shreg;
        perr_q  <= par_err;
        ferr_q  <= frm_err;
        valid_q <= 1'b1;
        ovr_q   <= 1'b0;
      end else begin
        ovr_q <= 1'b1;
      end
    end else if (valid_q && bus.data_ready) begin
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.overrun    = ovr_q;
  assign bus.busy       = busy_r;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Bench for uart_rx_oversampled: an 8N1 instance and an 8E2 instance, 8 clk per bit,
// directed scenarios plus random frames scored against a frame-level expectation queue.
module tb_uart_rx_oversampled;

  localparam int BIT_CLK = 8;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       ov;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   acc0 = 0, acc1 = 0;
  int   rdy_mode0 = 0, rdy_mode1 = 0;
  exp_t q0[$], q1[$];

  always #5 clk = ~clk;

  uart_rx_oversampled_if #(.DATA_BITS(8)) ifn ();
  uart_rx_oversampled_if #(.DATA_BITS(8)) ifp ();

  uart_rx_oversampled #(
    .DATA_BITS(8), .OVERSAMPLE(4), .CLKS_PER_TICK(2),
    .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)
  ) u_dut_n (.clk(clk), .rst(rst), .bus(ifn));

  uart_rx_oversampled #(
    .DATA_BITS(8), .OVERSAMPLE(4), .CLKS_PER_TICK(2),
    .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)
  ) u_dut_p (.clk(clk), .rst(rst), .bus(ifp));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic score(input int sel, input logic [7:0] d, input logic pe, input logic fe,
                       input logic ov);
    exp_t e;
    if ((sel == 0 && q0.size() == 0) || (sel == 1 && q1.size() == 0)) begin
      chk($sformatf("dut%0d_unexpected_word", sel), {24'd0, d}, 32'hFFFF_FFFF);
      return;
    end
    e = (sel == 0) ? q0.pop_front() : q1.pop_front();
    chk($sformatf("dut%0d_data", sel), {24'd0, d}, {24'd0, e.d});
    chk($sformatf("dut%0d_parity_err", sel), {31'd0, pe}, {31'd0, e.pe});
    chk($sformatf("dut%0d_frame_err", sel), {31'd0, fe}, {31'd0, e.fe});
    chk($sformatf("dut%0d_overrun", sel), {31'd0, ov}, {31'd0, e.ov});
  endtask

  // Monitor: every accepted word is popped and compared.
  always @(negedge clk) begin
    if (rst && ifn.data_valid && ifn.data_ready) begin
      acc0++;
      score(0, ifn.data_out, ifn.parity_err, ifn.frame_err, ifn.overrun);
    end
    if (rst && ifp.data_valid && ifp.data_ready) begin
      acc1++;
      score(1, ifp.data_out, ifp.parity_err, ifp.frame_err, ifp.overrun);
    end
  end

  // Consumer: 0 = hold off, 1 = always ready, 2 = random.
  initial forever begin
    @(posedge clk);
    #2;
    ifn.data_ready = (rdy_mode0 == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode0 == 1);
    ifp.data_ready = (rdy_mode1 == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode1 == 1);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic b);
    if (sel == 0) ifn.rx = b;
    else          ifp.rx = b;
  endtask

  task automatic send_bit(input int sel, input logic b);
    drive(sel, b);
    cyc(BIT_CLK);
  endtask

  task automatic send_frame(input int sel, input logic [7:0] d, input logic pbit,
                            input logic [1:0] stops, input bit push, input int gap);
    exp_t e;
    int   nst;
    nst  = (sel == 1) ? 2 : 1;
    e.d  = d;
    e.pe = (sel == 1) && ((($countones(d) + int'(pbit)) % 2) != 0);
    e.fe = (stops[0] == 1'b0) || (nst == 2 && stops[1] == 1'b0);
    e.ov = 1'b0;
    if (push) begin
      if (sel == 0) q0.push_back(e);
      else          q1.push_back(e);
    end
    send_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(sel, d[i]);
    if (sel == 1) send_bit(sel, pbit);
    for (int i = 0; i < nst; i++) send_bit(sel, stops[i]);
    for (int i = 0; i < gap; i++) send_bit(sel, 1'b1);
  endtask

  task automatic drain(input int sel);
    int k;
    k = 0;
    while (((sel == 0) ? q0.size() : q1.size()) != 0 && k < 400) begin
      cyc(1);
      k++;
    end
    chk($sformatf("dut%0d_drain_pending", sel), (sel == 0) ? q0.size() : q1.size(), 0);
  endtask

  initial begin
    int          a;
    logic [7:0]  d;
    logic [1:0]  st;
    logic        pb, last;
    int          gap;
    ifn.rx = 1'b1; ifn.rx_en = 1'b1; ifn.data_ready = 1'b0;
    ifp.rx = 1'b1; ifp.rx_en = 1'b1; ifp.data_ready = 1'b0;
    cyc(3);
    @(negedge clk);
    chk("reset_valid_n", ifn.data_valid, 0);
    chk("reset_busy_n", ifn.busy, 0);
    chk("reset_out_n", {ifn.data_out, ifn.parity_err, ifn.frame_err, ifn.overrun}, 0);
    chk("reset_valid_p", ifp.data_valid, 0);
    chk("reset_out_p", {ifp.data_out, ifp.busy, ifp.parity_err, ifp.frame_err, ifp.overrun}, 0);
    cyc(1);
    rst = 1'b1;
    cyc(4);

    // 1: held word while consumer stalls
    rdy_mode0 = 0;
    send_frame(0, 8'hA5, 1'b0, 2'b11, 1'b1, 1);
    cyc(20);
    chk("t1_valid_held", ifn.data_valid, 1);
    chk("t1_data_held", ifn.data_out, 8'hA5);
    chk("t1_busy_idle", ifn.busy, 0);
    rdy_mode0 = 1;
    drain(0);

    // 2: short low pulse is a glitch
    a = acc0;
    drive(0, 1'b0);
    cyc(3);
    drive(0, 1'b1);
    cyc(40);
    chk("t2_no_word", acc0 - a, 0);
    chk("t2_valid", ifn.data_valid, 0);
    chk("t2_busy", ifn.busy, 0);

    // 3: even parity, wrong then right parity bit
    rdy_mode1 = 1;
    send_frame(1, 8'h3C, 1'b1, 2'b11, 1'b1, 1);
    send_frame(1, 8'h3C, 1'b0, 2'b11, 1'b1, 1);
    drain(1);

    // 4: stop bit 0 followed by a held-low line
    a = acc0;
    send_frame(0, 8'h55, 1'b0, 2'b00, 1'b1, 0);
    cyc(40);
    chk("t4_break_busy", ifn.busy, 1);
    chk("t4_one_word", acc0 - a, 1);
    drive(0, 1'b1);
    cyc(24);
    chk("t4_no_retrigger", acc0 - a, 1);
    chk("t4_busy_after", ifn.busy, 0);
    drain(0);

    // 5: back-to-back frames into a stalled consumer
    rdy_mode0 = 0;
    send_frame(0, 8'h11, 1'b0, 2'b11, 1'b1, 0);
    send_frame(0, 8'h22, 1'b0, 2'b11, 1'b0, 1);
    q0[q0.size() - 1].ov = 1'b1;
    chk("t5_data_kept", ifn.data_out, 8'h11);
    chk("t5_overrun", ifn.overrun, 1);
    rdy_mode0 = 1;
    cyc(1);
    rdy_mode0 = 0;
    @(negedge clk);
    chk("t5_valid_clear", ifn.data_valid, 0);
    chk("t5_overrun_clear", ifn.overrun, 0);
    drain(0);

    // 6: reset in the middle of the data bits
    rdy_mode0 = 1;
    send_bit(0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(0, d[0] & 1'b0);
    rst = 1'b0;
    drive(0, 1'b1);
    cyc(1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_outputs", {ifn.data_out, ifn.data_valid, ifn.parity_err, ifn.frame_err,
                       ifn.overrun, ifn.busy}, 0);
    cyc(16);
    send_frame(0, 8'h5A, 1'b0, 2'b11, 1'b1, 1);
    drain(0);

    // Random frames on both formats
    rdy_mode0 = 2;
    rdy_mode1 = 2;
    for (int s = 0; s < 2; s++) begin
      for (int n = 0; n < 12; n++) begin
        d    = 8'($urandom);
        pb   = 1'($urandom);
        st   = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
        last = (s == 1) ? st[1] : st[0];
        gap  = $urandom_range(0, 2);
        if (!last && gap == 0) gap = 1;
        send_frame(s, d, pb, st, 1'b1, gap);
      end
      cyc(BIT_CLK);
      drain(s);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
